// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int LARGURA = 8;
  localparam int N_ITER  = 8;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIM  = 2'd2
  } estado_t;

endpackage

// File: rtl/divisor_sequencial_if.sv
// Request/result bundle between the operation path and the divider.
interface divisor_sequencial_if;
  import div_pkg::*;

  logic               start;
  logic               sel_div;
  logic [LARGURA-1:0] A;
  logic [LARGURA-1:0] B;
  logic               busy;
  logic               done;
  logic [LARGURA-1:0] quociente;
  logic [LARGURA-1:0] resto;
  logic               erro_div0;

  modport master (
    output start, sel_div, A, B,
    input  busy, done, quociente, resto, erro_div0
  );

  modport slave (
    input  start, sel_div, A, B,
    output busy, done, quociente, resto, erro_div0
  );

endinterface

// File: rtl/divisor_passo.sv
// One restoring shift-subtract step on a 9-bit partial remainder.
module divisor_passo
  import div_pkg::*;
(
  input  logic [LARGURA:0]   resto_i,
  input  logic               bit_i,
  input  logic [LARGURA-1:0] b_i,
  output logic [LARGURA:0]   resto_o,
  output logic               q_o
);

  logic [LARGURA:0]   desloc;
  logic [LARGURA+1:0] dif;
  logic               unused_msb;

  // The kept remainder is always below 2^8, so its MSB never carries information.
  assign unused_msb = resto_i[LARGURA];

  always_comb begin
    desloc  = {resto_i[LARGURA-1:0], bit_i};
    dif     = {1'b0, desloc} - {2'b00, b_i};
    q_o     = ~dif[LARGURA+1];
    resto_o = q_o ? dif[LARGURA:0] : desloc;
  end

endmodule

// File: rtl/divisor_sequencial.sv
// 8-bit sequential restoring divider, one quotient bit per CALC cycle.
// DIVISOR_FLAG_DIV0_EN: B=0 short-circuits to FIM and raises erro_div0.
module divisor_sequencial
  import div_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  divisor_sequencial_if.slave  bus
);

  estado_t            estado_q, estado_d;
  logic [LARGURA-1:0] a_q, a_d;
  logic [LARGURA-1:0] b_q, b_d;
  logic [LARGURA-1:0] quo_q, quo_d;
  logic [LARGURA-1:0] quociente_q, quociente_d;
  logic [LARGURA-1:0] resto_q, resto_d;
  logic [LARGURA:0]   parcial_q, parcial_d, parcial_novo;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               q_bit;
`ifdef DIVISOR_FLAG_DIV0_EN
  logic               erro_q, erro_d;
`endif

  // a_q shifts left each iteration so its MSB is always the next dividend bit.
  divisor_passo u_passo (
    .resto_i (parcial_q),
    .bit_i   (a_q[LARGURA-1]),
    .b_i     (b_q),
    .resto_o (parcial_novo),
    .q_o     (q_bit)
  );

  always_comb begin
    // NOTE: every _d gets a default first, so no branch can infer a latch.
    estado_d    = estado_q;
    a_d         = a_q;
    b_d         = b_q;
    quo_d       = quo_q;
    quociente_d = quociente_q;
    resto_d     = resto_q;
    parcial_d   = parcial_q;
    cnt_d       = cnt_q;
`ifdef DIVISOR_FLAG_DIV0_EN
    erro_d      = erro_q;
`endif
    case (estado_q)
      IDLE: begin
        if (bus.start && bus.sel_div) begin
          a_d       = bus.A;
          b_d       = bus.B;
          quo_d     = '0;
          parcial_d = '0;
          cnt_d     = '0;
          estado_d  = CALC;
`ifdef DIVISOR_FLAG_DIV0_EN
          erro_d    = 1'b0;
          if (bus.B == '0) begin
            estado_d    = FIM;
            erro_d      = 1'b1;
            quociente_d = '1;
            resto_d     = bus.A;
          end
`endif
        end
      end
      CALC: begin
        a_d       = {a_q[LARGURA-2:0], 1'b0};
        quo_d     = {quo_q[LARGURA-2:0], q_bit};
        parcial_d = parcial_novo;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N_ITER - 1)) begin
          estado_d    = FIM;
          quociente_d = {quo_q[LARGURA-2:0], q_bit};
          resto_d     = parcial_novo[LARGURA-1:0];
        end
      end
      FIM:     estado_d = IDLE;
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      estado_q    <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      quo_q       <= '0;
      quociente_q <= '0;
      resto_q     <= '0;
      parcial_q   <= '0;
      cnt_q       <= '0;
`ifdef DIVISOR_FLAG_DIV0_EN
      erro_q      <= 1'b0;
`endif
    end else begin
      estado_q    <= estado_d;
      a_q         <= a_d;
      b_q         <= b_d;
      quo_q       <= quo_d;
      quociente_q <= quociente_d;
      resto_q     <= resto_d;
      parcial_q   <= parcial_d;
      cnt_q       <= cnt_d;
`ifdef DIVISOR_FLAG_DIV0_EN
      erro_q      <= erro_d;
`endif
    end
  end

  assign bus.busy      = (estado_q == CALC);
  assign bus.done      = (estado_q == FIM);
  assign bus.quociente = quociente_q;
  assign bus.resto     = resto_q;
`ifdef DIVISOR_FLAG_DIV0_EN
  assign bus.erro_div0 = erro_q;
`else
  assign bus.erro_div0 = 1'b0;
`endif

endmodule

// File: tb/tb_divisor_sequencial.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level model.
module tb_divisor_sequencial;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  divisor_sequencial_if bus ();

  divisor_sequencial dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: cycles of busy left, a done flag, and the arithmetic result.
  int         m_left = 0;
  bit         m_done = 1'b0;
  bit         m_err  = 1'b0;
  logic [7:0] m_q = '0, m_r = '0;
  logic [7:0] p_q, p_r;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_done = 1'b0; m_err = 1'b0; m_q = '0; m_r = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1; m_q = p_q; m_r = p_r;
      end
    end else if (bus.start && bus.sel_div) begin
      p_q   = (bus.B == 8'd0) ? 8'hFF : 8'(bus.A / bus.B);
      p_r   = (bus.B == 8'd0) ? bus.A : 8'(bus.A % bus.B);
      m_err = 1'b0;
`ifdef DIVISOR_FLAG_DIV0_EN
      if (bus.B == 8'd0) begin
        m_done = 1'b1; m_q = p_q; m_r = p_r; m_err = 1'b1;
      end else
`endif
        m_left = N_ITER;
    end
    #1;
    check("busy", 32'(bus.busy), 32'(m_left > 0));
    check("done", 32'(bus.done), 32'(m_done));
    check("quociente", 32'(bus.quociente), 32'(m_q));
    check("resto", 32'(bus.resto), 32'(m_r));
    check("erro_div0", 32'(bus.erro_div0), 32'(m_err));
  end

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat, output int nb);
    @(negedge clk);
    bus.A = a; bus.B = b; bus.start = 1'b1; bus.sel_div = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0; nb = 0;
    for (int i = 1; i <= 20; i++) begin
      if (bus.busy) nb++;
      if (bus.done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  int lat, nb;

  initial begin
    bus.start = 1'b0; bus.sel_div = 1'b0; bus.A = '0; bus.B = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset quociente", 32'(bus.quociente), 0);
    check("reset busy", 32'(bus.busy), 0);
    rst = 1'b0;

    run_op(8'd100, 8'd7, lat, nb);
    check("100/7 quociente", 32'(bus.quociente), 14);
    check("100/7 resto", 32'(bus.resto), 2);
    check("100/7 busy cycles", nb, 8);
    check("100/7 latency", lat, 9);

    run_op(8'd255, 8'd1, lat, nb);
    check("255/1 quociente", 32'(bus.quociente), 255);
    check("255/1 resto", 32'(bus.resto), 0);

    run_op(8'd5, 8'd9, lat, nb);
    check("5/9 quociente", 32'(bus.quociente), 0);
    check("5/9 resto", 32'(bus.resto), 5);

    run_op(8'd42, 8'd0, lat, nb);
    check("42/0 quociente", 32'(bus.quociente), 255);
    check("42/0 resto", 32'(bus.resto), 42);
`ifdef DIVISOR_FLAG_DIV0_EN
    check("42/0 latency", lat, 1);
    check("42/0 busy cycles", nb, 0);
    check("42/0 erro_div0", 32'(bus.erro_div0), 1);
`else
    check("42/0 latency", lat, 9);
    check("42/0 busy cycles", nb, 8);
    check("42/0 erro_div0", 32'(bus.erro_div0), 0);
`endif

    // start without sel_div must be ignored.
    @(negedge clk);
    bus.A = 8'd3; bus.B = 8'd1; bus.start = 1'b1; bus.sel_div = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("no-sel busy", 32'(bus.busy), 0);
      check("no-sel done", 32'(bus.done), 0);
    end
    bus.start = 1'b0;
    check("no-sel quociente held", 32'(bus.quociente), 255);

    // Inputs toggled and start re-pulsed during CALC.
    @(negedge clk);
    bus.A = 8'd200; bus.B = 8'd13; bus.start = 1'b1; bus.sel_div = 1'b1;
    @(negedge clk);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (bus.done) begin
        lat = i;
        bus.start = 1'b0;
        break;
      end
      bus.A = 8'($urandom); bus.B = 8'($urandom);
      bus.start = 1'($urandom); bus.sel_div = 1'($urandom);
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("toggle quociente", 32'(bus.quociente), 15);
    check("toggle resto", 32'(bus.resto), 5);
    check("toggle latency", lat, 9);
    repeat (2) @(negedge clk);
    check("repulse ignored", 32'(bus.busy), 0);

    // Reset during the 4th CALC cycle.
    bus.A = 8'd77; bus.B = 8'd5; bus.start = 1'b1; bus.sel_div = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("4th CALC busy", 32'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort quociente", 32'(bus.quociente), 0);
    check("abort resto", 32'(bus.resto), 0);
    check("abort busy", 32'(bus.busy), 0);
    check("abort done", 32'(bus.done), 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort no done", 32'(bus.done), 0);
    end

    // Random traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst         = ($urandom_range(199) == 0);
      bus.start   = ($urandom_range(2) == 0);
      bus.sel_div = ($urandom_range(3) != 0);
      bus.A       = 8'($urandom);
      bus.B       = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
